// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cache-line memory port arbiter.
//   mem_arb_owner_t : which requester owns the outstanding transaction
//   arb_state_t     : arbiter FSM states
//   MEM_LW_LINE     : line-fill opcode, used for every prefetch request
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_L1D = 2'd0,
        OWN_L1I = 2'd1,
        OWN_PF  = 2'd2
    } mem_arb_owner_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } arb_state_t;

    localparam logic [3:0] MEM_LW_LINE = 4'd7;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the memory port arbiter.
//   l1d_valid/l1i_valid/pf_valid : pending requests
//   last_gnt                     : last L1D/L1I grant, for round-robin
//   pf_starved                   : PF has lost too many selections in a row
//   hold                         : suppress any grant
//   sel_valid/sel_owner          : a grant is made, and to whom
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic           l1d_valid,
    input  logic           l1i_valid,
    input  logic           pf_valid,
    input  mem_arb_owner_t last_gnt,
    input  logic           pf_starved,
    input  logic           hold,
    output logic           sel_valid,
    output mem_arb_owner_t sel_owner
);

    always_comb begin
        sel_valid = !hold && (l1d_valid || l1i_valid || pf_valid);
        sel_owner = OWN_PF;
        if (pf_starved && pf_valid)
            sel_owner = OWN_PF;
        else if (l1d_valid && l1i_valid)
            // Round-robin only between the caches; PF is lowest priority.
            sel_owner = (last_gnt == OWN_L1I) ? OWN_L1D : OWN_L1I;
        else if (l1d_valid)
            sel_owner = OWN_L1D;
        else if (l1i_valid)
            sel_owner = OWN_L1I;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the cache-line memory port between L1D, L1I and the
// next-line prefetcher, one transaction outstanding at a time.
//   l1d_req_* / l1i_req_* / pf_req_* : requests (valid held until ack)
//   *_req_ack                        : one-cycle accept pulse, first WAIT_RSP cycle
//   *_rsp_valid                      : response strobe routed to the owner
//   hold_grants                      : block new grants (in-flight one completes)
//   mem_req_* / mem_rsp_valid        : external memory port
//   busy                             : a transaction is outstanding
//   timeout_err / spurious_rsp_err   : sticky error flags
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int M_WIDTH         = 32,
    parameter int CL_BITS         = 128,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int PF_STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l1d_req_valid,
    input  logic [M_WIDTH-1:0] l1d_req_addr,
    input  logic [3:0]         l1d_req_opcode,
    input  logic [CL_BITS-1:0] l1d_req_store_data,
    output logic               l1d_req_ack,
    output logic               l1d_rsp_valid,
    input  logic               l1i_req_valid,
    input  logic [M_WIDTH-1:0] l1i_req_addr,
    input  logic [3:0]         l1i_req_opcode,
    output logic               l1i_req_ack,
    output logic               l1i_rsp_valid,
    input  logic               pf_req_valid,
    input  logic [M_WIDTH-1:0] pf_req_addr,
    output logic               pf_req_ack,
    output logic               pf_rsp_valid,
    input  logic               hold_grants,
    output logic               mem_req_valid,
    output logic [M_WIDTH-1:0] mem_req_addr,
    output logic [3:0]         mem_req_opcode,
    output logic [CL_BITS-1:0] mem_req_store_data,
    input  logic               mem_rsp_valid,
    output logic               busy,
    output logic               timeout_err,
    output logic               spurious_rsp_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PS_W = $clog2(PF_STARVE_LIMIT + 1);

    arb_state_t     state, state_nxt;
    mem_arb_owner_t owner, last_gnt, sel_owner;
    logic           sel_valid, take;
    logic [PS_W-1:0] pf_starve_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic [M_WIDTH-1:0] sel_addr;
    logic [3:0]         sel_opcode;
    logic [CL_BITS-1:0] sel_data;

    mem_arb_pick u_pick (
        .l1d_valid  (l1d_req_valid),
        .l1i_valid  (l1i_req_valid),
        .pf_valid   (pf_req_valid),
        .last_gnt   (last_gnt),
        .pf_starved (pf_starve_cnt == PS_W'(PF_STARVE_LIMIT)),
        .hold       (hold_grants),
        .sel_valid  (sel_valid),
        .sel_owner  (sel_owner)
    );

    assign take = (state == IDLE) && sel_valid;

    // Only L1D ever carries store data; L1I and PF fetch lines.
    always_comb begin
        sel_addr   = pf_req_addr;
        sel_opcode = MEM_LW_LINE;
        sel_data   = '0;
        case (sel_owner)
            OWN_L1D: begin
                sel_addr   = l1d_req_addr;
                sel_opcode = l1d_req_opcode;
                sel_data   = l1d_req_store_data;
            end
            OWN_L1I: begin
                sel_addr   = l1i_req_addr;
                sel_opcode = l1i_req_opcode;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (sel_valid)     state_nxt = WAIT_RSP;
            WAIT_RSP: if (mem_rsp_valid) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    assign busy          = (state == WAIT_RSP);
    assign mem_req_valid = busy;
    assign l1d_rsp_valid = busy && mem_rsp_valid && (owner == OWN_L1D);
    assign l1i_rsp_valid = busy && mem_rsp_valid && (owner == OWN_L1I);
    assign pf_rsp_valid  = busy && mem_rsp_valid && (owner == OWN_PF);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner              <= OWN_L1D;
            last_gnt           <= OWN_L1I;   // L1D wins the first tie
            l1d_req_ack        <= 1'b0;
            l1i_req_ack        <= 1'b0;
            pf_req_ack         <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_opcode     <= '0;
            mem_req_store_data <= '0;
            pf_starve_cnt      <= '0;
            wd_cnt             <= '0;
            timeout_err        <= 1'b0;
            spurious_rsp_err   <= 1'b0;
        end else begin
            // Acks are registered, so each grant pulses exactly once.
            l1d_req_ack <= take && (sel_owner == OWN_L1D);
            l1i_req_ack <= take && (sel_owner == OWN_L1I);
            pf_req_ack  <= take && (sel_owner == OWN_PF);

            if (take) begin
                owner              <= sel_owner;
                mem_req_addr       <= sel_addr;
                mem_req_opcode     <= sel_opcode;
                mem_req_store_data <= sel_data;
                wd_cnt             <= '0;
                if (sel_owner != OWN_PF) last_gnt <= sel_owner;
            end else if (state == WAIT_RSP) begin
                if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
                // Flag only; the transaction keeps waiting for its response.
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
            end

            if (!pf_req_valid)
                pf_starve_cnt <= '0;
            else if (take) begin
                if (sel_owner == OWN_PF)
                    pf_starve_cnt <= '0;
                else if (pf_starve_cnt != PS_W'(PF_STARVE_LIMIT))
                    pf_starve_cnt <= pf_starve_cnt + PS_W'(1);
            end

            if ((state == IDLE) && mem_rsp_valid) spurious_rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic         clk, reset;
    logic         l1d_req_valid, l1d_req_ack, l1d_rsp_valid;
    logic [31:0]  l1d_req_addr;
    logic [3:0]   l1d_req_opcode;
    logic [127:0] l1d_req_store_data;
    logic         l1i_req_valid, l1i_req_ack, l1i_rsp_valid;
    logic [31:0]  l1i_req_addr;
    logic [3:0]   l1i_req_opcode;
    logic         pf_req_valid, pf_req_ack, pf_rsp_valid;
    logic [31:0]  pf_req_addr;
    logic         hold_grants, mem_req_valid, mem_rsp_valid;
    logic [31:0]  mem_req_addr;
    logic [3:0]   mem_req_opcode;
    logic [127:0] mem_req_store_data;
    logic         busy, timeout_err, spurious_rsp_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .l1d_req_valid(l1d_req_valid), .l1d_req_addr(l1d_req_addr),
        .l1d_req_opcode(l1d_req_opcode), .l1d_req_store_data(l1d_req_store_data),
        .l1d_req_ack(l1d_req_ack), .l1d_rsp_valid(l1d_rsp_valid),
        .l1i_req_valid(l1i_req_valid), .l1i_req_addr(l1i_req_addr),
        .l1i_req_opcode(l1i_req_opcode), .l1i_req_ack(l1i_req_ack),
        .l1i_rsp_valid(l1i_rsp_valid),
        .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr),
        .pf_req_ack(pf_req_ack), .pf_rsp_valid(pf_rsp_valid),
        .hold_grants(hold_grants),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_opcode(mem_req_opcode), .mem_req_store_data(mem_req_store_data),
        .mem_rsp_valid(mem_rsp_valid),
        .busy(busy), .timeout_err(timeout_err), .spurious_rsp_err(spurious_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim still running, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        l1d_req_valid = 0; l1d_req_addr = '0; l1d_req_opcode = '0; l1d_req_store_data = '0;
        l1i_req_valid = 0; l1i_req_addr = '0; l1i_req_opcode = '0;
        pf_req_valid = 0; pf_req_addr = '0;
        hold_grants = 0; mem_rsp_valid = 0;
    endtask

    task automatic apply_reset();
        reset = 1; clear_inputs();
        repeat (2) tick();
        reset = 0;
    endtask

    // Polls for an ack for up to budget cycles; who = 0 L1D, 1 L1I, 2 PF, 3 none.
    task automatic find_ack(input int budget, output logic [1:0] who);
        who = 2'd3;
        for (int i = 0; i < budget; i++) begin
            if (l1d_req_ack)     begin who = 2'd0; return; end
            else if (l1i_req_ack) begin who = 2'd1; return; end
            else if (pf_req_ack)  begin who = 2'd2; return; end
            tick();
        end
    endtask

    // One-cycle response pulse; rv = {pf, l1i, l1d} rsp_valid during the pulse.
    task automatic rsp_pulse(output logic [2:0] rv);
        mem_rsp_valid = 1; #1;
        rv = {pf_rsp_valid, l1i_rsp_valid, l1d_rsp_valid};
        tick();
        mem_rsp_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        l1d_req_valid = 1; mem_rsp_valid = 1;
        repeat (2) tick();
        vectors++;
        if ({l1d_req_ack, l1i_req_ack, pf_req_ack, l1d_rsp_valid, l1i_rsp_valid, pf_rsp_valid,
             mem_req_valid, busy, timeout_err, spurious_rsp_err} !== 10'b0 ||
            mem_req_addr !== 32'h0 || mem_req_opcode !== 4'h0 || mem_req_store_data !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack/rsp/flags nonzero or fields %h/%h, required all 0",
                     mem_req_addr, mem_req_opcode);
        end
        reset = 0; clear_inputs();
        tick();
        vectors++;
        if (busy !== 1'b0 || spurious_rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b spurious=%b, required 0 0", busy, spurious_rsp_err);
        end
    endtask

    task automatic test_single_l1d();
        logic [2:0] rv;
        apply_reset();
        l1d_req_valid = 1; l1d_req_addr = 32'h1000; l1d_req_opcode = 4'd4;
        l1d_req_store_data = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        #1;
        vectors++;
        if (l1d_req_ack !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c0: ack=%b mem_req_valid=%b, required 0 0", l1d_req_ack, mem_req_valid);
        end
        tick();
        vectors++;
        if (l1d_req_ack !== 1'b1 || l1i_req_ack !== 1'b0 || pf_req_ack !== 1'b0 || mem_req_valid !== 1'b1 ||
            busy !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_opcode !== 4'd4 ||
            mem_req_store_data !== 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa) begin
            miscompares++;
            $display("FAIL single_c1: ack=%b valid=%b addr=%h op=%h, required 1 1 00001000 4",
                     l1d_req_ack, mem_req_valid, mem_req_addr, mem_req_opcode);
        end
        l1d_req_valid = 0; l1d_req_addr = 32'h2222;
        tick();
        vectors++;
        if (l1d_req_ack !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin
            miscompares++;
            $display("FAIL single_c2: ack=%b valid=%b addr=%h, required 0 1 00001000",
                     l1d_req_ack, mem_req_valid, mem_req_addr);
        end
        repeat (3) tick();
        rsp_pulse(rv);
        vectors++;
        if (rv !== 3'b001) begin
            miscompares++;
            $display("FAIL single_rsp_c5: rsp {pf,l1i,l1d}=%b, required 001", rv);
        end
        vectors++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || l1d_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c6: busy=%b valid=%b rsp=%b, required 0 0 0", busy, mem_req_valid, l1d_rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] who;
        logic [2:0] rv;
        logic [1:0] exp_own [4];
        int prev;
        exp_own = '{2'd0, 2'd1, 2'd0, 2'd1};
        prev = 0;
        apply_reset();
        l1d_req_valid = 1; l1d_req_addr = 32'h40; l1d_req_opcode = 4'd4;
        l1i_req_valid = 1; l1i_req_addr = 32'h80; l1i_req_opcode = 4'd2;
        for (int g = 0; g < 4; g++) begin
            find_ack(20, who);
            vectors++;
            if (who !== exp_own[g] || (g > 0 && cyc - prev != 4)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: owner=%0d spacing=%0d, required owner=%0d spacing=4",
                         g, who, cyc - prev, exp_own[g]);
            end
            prev = cyc;
            repeat (2) tick();
            rsp_pulse(rv);
            vectors++;
            if (rv !== (exp_own[g] == 2'd0 ? 3'b001 : 3'b010)) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: rsp {pf,l1i,l1d}=%b, required owner %0d only", g, rv, exp_own[g]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_pf_starve();
        logic [1:0] who;
        logic [2:0] rv;
        apply_reset();
        l1d_req_valid = 1; l1d_req_addr = 32'h100; l1d_req_opcode = 4'd4;
        l1d_req_store_data = 128'h1234;
        l1i_req_valid = 1; l1i_req_addr = 32'h200; l1i_req_opcode = 4'd2;
        pf_req_valid  = 1; pf_req_addr  = 32'h300;
        for (int g = 0; g < 17; g++) begin
            find_ack(20, who);
            vectors++;
            if (g < 16) begin
                if (who !== 2'(g % 2)) begin
                    miscompares++;
                    $display("FAIL starve_loss%0d: owner=%0d, required %0d", g, who, g % 2);
                end
            end else begin
                if (who !== 2'd2 || mem_req_opcode !== MEM_LW_LINE || mem_req_addr !== 32'h300 ||
                    mem_req_store_data !== 128'h0 || dut.pf_starve_cnt !== '0) begin
                    miscompares++;
                    $display("FAIL starve_pf_win: owner=%0d op=%h addr=%h cnt=%0d, required 2 %h 00000300 0",
                             who, mem_req_opcode, mem_req_addr, dut.pf_starve_cnt, MEM_LW_LINE);
                end
                pf_req_valid = 0;
            end
            repeat (2) tick();
            rsp_pulse(rv);
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        logic [2:0] rv;
        int bad;
        bad = 0;
        apply_reset();
        hold_grants = 1;
        l1d_req_valid = 1; l1d_req_addr = 32'h500; l1d_req_opcode = 4'd4;
        l1i_req_valid = 1; l1i_req_addr = 32'h600;
        pf_req_valid  = 1; pf_req_addr  = 32'h700;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (l1d_req_ack || l1i_req_ack || pf_req_ack || mem_req_valid) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_block: %0d cycles with ack/mem_req_valid, required 0", bad);
        end
        hold_grants = 0;
        tick();
        vectors++;
        if ({pf_req_ack, l1i_req_ack, l1d_req_ack} !== 3'b001 || mem_req_addr !== 32'h500) begin
            miscompares++;
            $display("FAIL hold_release: acks {pf,l1i,l1d}=%b addr=%h, required 001 00000500",
                     {pf_req_ack, l1i_req_ack, l1d_req_ack}, mem_req_addr);
        end
        l1d_req_valid = 0;
        hold_grants = 1;   // must not disturb the in-flight transaction
        repeat (2) tick();
        rsp_pulse(rv);
        vectors++;
        if (rv !== 3'b001) begin
            miscompares++;
            $display("FAIL hold_inflight_rsp: rsp {pf,l1i,l1d}=%b, required 001", rv);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (l1i_req_ack || pf_req_ack || mem_req_valid) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_reblock: %0d cycles with grant, required 0", bad);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic [1:0] who;
        logic [2:0] rv;
        apply_reset();
        l1i_req_valid = 1; l1i_req_addr = 32'h900; l1i_req_opcode = 4'd2;
        l1d_req_store_data = 128'hffff;   // must not leak into an L1I request
        find_ack(5, who);
        vectors++;
        if (who !== 2'd1 || mem_req_store_data !== 128'h0 || mem_req_opcode !== 4'd2) begin
            miscompares++;
            $display("FAIL timeout_grant: owner=%0d data=%h op=%h, required 1 0 2",
                     who, mem_req_store_data, mem_req_opcode);
        end
        l1i_req_valid = 0;
        repeat (1000) tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: timeout_err=%b busy=%b, required 0 1", timeout_err, busy);
        end
        repeat (30) tick();
        vectors++;
        if (timeout_err !== 1'b1 || mem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: timeout_err=%b valid=%b, required 1 1", timeout_err, mem_req_valid);
        end
        rsp_pulse(rv);
        vectors++;
        if (rv !== 3'b010 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_late_rsp: rsp=%b timeout_err=%b busy=%b, required 010 1 0",
                     rv, timeout_err, busy);
        end
        clear_inputs();
    endtask

    task automatic test_spurious_and_reset();
        logic [1:0] who;
        logic [2:0] rv;
        apply_reset();
        rsp_pulse(rv);
        vectors++;
        if (rv !== 3'b000 || spurious_rsp_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_idle: rsp=%b err=%b busy=%b, required 000 1 0", rv, spurious_rsp_err, busy);
        end
        tick();
        vectors++;
        if (spurious_rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_sticky: err=%b, required 1", spurious_rsp_err);
        end
        // Reset while a transaction is outstanding.
        apply_reset();
        l1d_req_valid = 1; l1d_req_addr = 32'hABC0; l1d_req_opcode = 4'd4;
        find_ack(5, who);
        l1d_req_valid = 0;
        tick();
        vectors++;
        if (busy !== 1'b1 || who !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_setup: busy=%b owner=%0d, required 1 0", busy, who);
        end
        reset = 1;
        tick();
        vectors++;
        if ({l1d_req_ack, l1i_req_ack, pf_req_ack, l1d_rsp_valid, l1i_rsp_valid, pf_rsp_valid,
             mem_req_valid, busy, timeout_err, spurious_rsp_err} !== 10'b0 ||
            mem_req_addr !== 32'h0 || mem_req_opcode !== 4'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b valid=%b addr=%h, required all 0",
                     busy, mem_req_valid, mem_req_addr);
        end
        reset = 0;
        tick();
        rsp_pulse(rv);
        vectors++;
        if (rv !== 3'b000 || spurious_rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_late_rsp: rsp=%b err=%b, required 000 1", rv, spurious_rsp_err);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_l1d();
        test_round_robin();
        test_pf_starve();
        test_hold();
        test_timeout();
        test_spurious_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
